ship_hit_detector: RTL
======================

# ship_hit_detector

Pixel-level collision detector for the player ship: flags a frame in which any ship pixel coincided with a hazard pixel (enemy or enemy bullet), then emits one clean `hit` pulse. After each hit it holds an invulnerability window of a configurable number of frames. It sits directly upstream of the ship hit counter, which counts rising edges of `hit`. It guarantees at most one rising edge per collision event, regardless of how many pixels overlap.

## Interface
- `HIT_HOLD`, default 4: number of pclk cycles `hit` stays high per event; legal range 1..15.
- `COOLDOWN_FRAMES`, default 60: invulnerability length in frames after a hit; legal range 0..255.
- `pclk` in 1: pixel clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `vblnk` in 1: vertical blanking from the VGA timing block; high during blanking.
- `ship_px` in 1: current pixel is an opaque ship pixel.
- `hazard_px` in 1: current pixel is an opaque enemy or enemy-bullet pixel.
- `enable` in 1: game running; low freezes and disarms the detector.
- `hit` out 1: registered level to the hit counter.
- `invulnerable` out 1: registered; high throughout HIT and COOLDOWN (used for ship blinking).
- `cooldown_left` out 8: registered; frames of invulnerability remaining.

## Operation
- Frame boundary (`fb`) is the cycle where sampled `vblnk`=1 and the previous sampled `vblnk`=0. This requires one internal register, `vblnk_d`.
- Overlap is `ship_px & hazard_px & enable & ~vblnk`.
- States:
  - ARMED: a sticky `collide` flag sets on overlap. On `fb`: if `collide` (or overlap in the same cycle, which cannot happen since `vblnk`=1), go to HIT, clear `collide` and load the hold counter with `HIT_HOLD`-1. Otherwise stay and clear `collide`.
  - HIT: `hit`=1. Decrement the hold counter each cycle. When it is 0, go to COOLDOWN and load `cooldown_left`=`COOLDOWN_FRAMES`. If `COOLDOWN_FRAMES`=0, go straight to ARMED. Overlaps are ignored.
  - COOLDOWN: overlaps are ignored and `collide` stays 0. Each `fb` decrements `cooldown_left`. If `fb` occurs with `cooldown_left`=1, go to ARMED with `cooldown_left` becoming 0.
- `enable`=0 in any state: on the next edge go to ARMED, clear `collide` and `hold`, and set `hit`=0, `cooldown_left`=0. Enable has priority over all transitions.
- State encoding: ARMED=2'b00, HIT=2'b01, COOLDOWN=2'b10. The unused code 2'b11 returns to ARMED.
- Width rules:
  - The hold counter is 4 bits.
  - `cooldown_left` is 8 bits and never wraps. A decrement at 0 is impossible by construction.

## Timing
- Reset (asynchronous) forces:
  - state=ARMED
  - `hit`=0, `invulnerable`=0, `cooldown_left`=0
  - `collide`=0, `vblnk_d`=0, hold counter=0
- Release of reset takes effect on the next pclk edge.
- Latency: `hit` rises at the pclk edge that samples the first `vblnk`=1 after a frame containing overlap. It stays high for exactly `HIT_HOLD` cycles.
- `invulnerable` rises with `hit`. It falls at the edge where state returns to ARMED.
- Overlap on the last active pixel before blanking counts for that frame.
- Overlap during blanking never counts.
- After a hit with `COOLDOWN_FRAMES`=0, `hit` is low for at least the remainder of that frame. The downstream counter therefore always sees distinct edges.
- `vblnk` stuck high produces no further `fb`. The state holds, except that HIT still completes its hold and moves on.
- Reset mid-HIT drops `hit` immediately (asynchronously).

## Structure
- The shared header `ship_defs.vh` holds the state encodings and the default `HIT_HOLD` and `COOLDOWN_FRAMES` values.
- Sub-module `frame_edge_detect` (`pclk`, `rst`, `vblnk` -> `fb`) contains the registered rising-edge detector and is reusable by the enemy blocks.
- Everything else (state register, hold counter, cooldown counter, `collide` flag) lives in `ship_hit_detector`. Next-state logic and output logic are kept separate, all outputs are registered.

## Test plan
- Reset: assert `rst` mid-frame with `ship_px`=`hazard_px`=1 -> `hit`=0, `invulnerable`=0 and `cooldown_left`=0 asynchronously, and no `hit` after release until a full overlap frame has ended.
- Single overlap pixel in frame N with `HIT_HOLD`=4 and `COOLDOWN_FRAMES`=3 -> `hit` high for exactly 4 cycles starting at frame N's `fb`. `cooldown_left` goes 3,2,1,0 at successive `fb`s, and `invulnerable` falls at the third `fb` after the hit.
- 500 overlap pixels in one frame -> exactly one `hit` pulse (one rising edge).
- Overlap in every frame during cooldown (`COOLDOWN_FRAMES`=3) -> no `hit` until ARMED; the first overlap frame after re-arming then yields a hit at its `fb`.
- Overlap only while `vblnk`=1 -> no `hit`. Overlap on the last active pixel -> `hit` at the next `fb`.
- `enable` dropped during HIT, then raised -> `hit` low on the next edge, `cooldown_left`=0 and state ARMED. With `COOLDOWN_FRAMES`=0, two consecutive overlap frames produce two separate `hit` pulses.

Source files
------------

// File: rtl/ship_hit_detector_pkg.sv
// Shared definitions for the ship hit detector: state encodings and
// default timing parameters.
package ship_hit_detector_pkg;

   typedef enum logic [1:0] {
      ARMED    = 2'b00,
      HIT      = 2'b01,
      COOLDOWN = 2'b10
   } state_t;

   localparam int unsigned HIT_HOLD_DEFAULT        = 4;
   localparam int unsigned COOLDOWN_FRAMES_DEFAULT = 60;

endpackage

// File: rtl/ship_hit_detector_if.sv
// Pixel/timing inputs and hit/invulnerability outputs of the ship hit detector.
interface ship_hit_detector_if;

   logic       vblnk;
   logic       ship_px;
   logic       hazard_px;
   logic       enable;
   logic       hit;
   logic       invulnerable;
   logic [7:0] cooldown_left;

   modport master (
      output vblnk, ship_px, hazard_px, enable,
      input  hit, invulnerable, cooldown_left
   );

   modport slave (
      input  vblnk, ship_px, hazard_px, enable,
      output hit, invulnerable, cooldown_left
   );

endinterface

// File: rtl/ship_hit_detector_frame_edge_detect.sv
// Frame boundary detector: one-cycle pulse on the first sampled cycle of vblnk=1.
module frame_edge_detect (
   input  logic pclk,
   input  logic rst,
   input  logic vblnk,
   output logic fb
);

   logic vblnk_d;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) vblnk_d <= 1'b0;
      else     vblnk_d <= vblnk;
   end

   assign fb = vblnk & ~vblnk_d;

endmodule

// File: rtl/ship_hit_detector.sv
// Ship/hazard pixel collision detector: one hit pulse per colliding frame,
// followed by a frame-counted invulnerability window.
module ship_hit_detector
   import ship_hit_detector_pkg::*;
#(
   parameter int unsigned HIT_HOLD        = HIT_HOLD_DEFAULT,
   parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
   input  logic               pclk,
   input  logic               rst,
   ship_hit_detector_if.slave bus
);

   localparam logic [3:0] HOLD_LOAD = 4'(HIT_HOLD - 1);
   localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_FRAMES);

   state_t     state, state_nx;
   logic [3:0] hold, hold_nx;
   logic [7:0] cool, cool_nx;
   logic       collide, collide_nx;
   logic       hit_q, hit_nx;
   logic       inv_q, inv_nx;
   logic       fb;
   logic       overlap;

   frame_edge_detect u_fb (
      .pclk  (pclk),
      .rst   (rst),
      .vblnk (bus.vblnk),
      .fb    (fb)
   );

   assign overlap = bus.ship_px & bus.hazard_px & bus.enable & ~bus.vblnk;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state   <= ARMED;
         hold    <= '0;
         cool    <= '0;
         collide <= 1'b0;
         hit_q   <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         hold    <= hold_nx;
         cool    <= cool_nx;
         collide <= collide_nx;
         hit_q   <= hit_nx;
         inv_q   <= inv_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (!bus.enable) begin
         state_nx = ARMED;
      end else begin
         case (state)
            ARMED:    if (fb && (collide || overlap)) state_nx = HIT;
            HIT:      if (hold == 4'd0) state_nx = (COOLDOWN_FRAMES == 0) ? ARMED : COOLDOWN;
            COOLDOWN: if (fb && cool == 8'd1) state_nx = ARMED;
            default:  state_nx = ARMED;
         endcase
      end
   end

   // Outputs are registered from the next state so hit/invulnerable
   // change on the same edge as the state they describe.
   always_comb begin
      collide_nx = collide;
      hold_nx    = hold;
      cool_nx    = cool;
      if (!bus.enable) begin
         collide_nx = 1'b0;
         hold_nx    = '0;
         cool_nx    = '0;
      end else begin
         case (state)
            ARMED: begin
               if (fb) begin
                  collide_nx = 1'b0;
                  if (collide || overlap) hold_nx = HOLD_LOAD;
               end else begin
                  collide_nx = collide | overlap;
               end
            end
            HIT: begin
               collide_nx = 1'b0;
               if (hold == 4'd0) cool_nx = COOL_LOAD;
               else              hold_nx = hold - 4'd1;
            end
            COOLDOWN: begin
               collide_nx = 1'b0;
               if (fb && cool != 8'd0) cool_nx = cool - 8'd1;
            end
            default: begin
               collide_nx = 1'b0;
               hold_nx    = '0;
               cool_nx    = '0;
            end
         endcase
      end
      hit_nx = (state_nx == HIT);
      inv_nx = (state_nx != ARMED);
   end

   assign bus.hit           = hit_q;
   assign bus.invulnerable  = inv_q;
   assign bus.cooldown_left = cool;

endmodule
